// File: rtl/piso_tx.sv
// ---------------------------------------------------------------------------
// piso_tx -- parallel-in / serial-out transmitter with one-word holding slot.
//
// A word is taken on any rising edge where load_valid and load_ready are both
// high. An idle shifter loads the word directly. A busy shifter parks it in a
// holding register instead. Bits leave one per clock from the end of the
// shifter that MSB_FIRST selects. A held word follows the current one without
// any idle cycle between them.
//
// Parameters
//   WIDTH      word length in bits (2..32)
//   MSB_FIRST  1: MSB leaves first, 0: LSB leaves first
// Ports
//   clk         sole clock, rising edge
//   rst         asynchronous reset, active low
//   par_in      parallel word offered for transmission
//   load_valid  par_in holds a word to transmit
//   load_ready  a word can be taken this cycle (holding slot empty)
//   serial_out  current transmitted bit (0 while idle)
//   bit_valid   serial_out carries a data bit
//   first_bit   serial_out is the first bit of a word
//   last_bit    serial_out is the final bit of a word
//   busy        shifter transmitting or holding slot occupied
// ---------------------------------------------------------------------------
module piso_tx #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] par_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             serial_out,
    output logic             bit_valid,
    output logic             first_bit,
    output logic             last_bit,
    output logic             busy
);

    localparam int              CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] hold_reg;
    logic             hold_full_reg;
    logic [CW-1:0]    cnt_reg;

    logic [WIDTH-1:0] shift_next;
    logic             out_bit;
    logic             accept;
    logic             is_last;

    // Shift direction and output tap are fixed at elaboration time.
    generate
        if (MSB_FIRST) begin : g_msb
            assign shift_next = {shift_reg[WIDTH-2:0], 1'b0};
            assign out_bit    = shift_reg[WIDTH-1];
        end else begin : g_lsb
            assign shift_next = {1'b0, shift_reg[WIDTH-1:1]};
            assign out_bit    = shift_reg[0];
        end
    endgenerate

    // Readiness depends on registered state only, so load_valid never
    // reaches load_ready combinationally. A full slot also blocks the edge
    // that empties it.
    assign accept  = load_valid & ~hold_full_reg;
    assign is_last = (cnt_reg == CNT_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            shift_reg     <= '0;
            hold_reg      <= '0;
            hold_full_reg <= 1'b0;
            cnt_reg       <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        shift_reg <= par_in;
                        cnt_reg   <= '0;
                        state_reg <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (is_last) begin
                        cnt_reg <= '0;
                        if (hold_full_reg) begin
                            // Held word follows immediately.
                            shift_reg     <= hold_reg;
                            hold_full_reg <= 1'b0;
                        end else if (accept) begin
                            // Word taken on the final edge skips the slot.
                            shift_reg <= par_in;
                        end else begin
                            shift_reg <= '0;
                            state_reg <= IDLE;
                        end
                    end else begin
                        shift_reg <= shift_next;
                        cnt_reg   <= cnt_reg + CW'(1);
                        if (accept) begin
                            hold_reg      <= par_in;
                            hold_full_reg <= 1'b1;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Outputs are decoded from registers only.
    assign load_ready = ~hold_full_reg;
    assign bit_valid  = (state_reg == SHIFT);
    assign serial_out = (state_reg == SHIFT) & out_bit;
    assign first_bit  = (state_reg == SHIFT) & (cnt_reg == '0);
    assign last_bit   = (state_reg == SHIFT) & is_last;
    assign busy       = (state_reg == SHIFT) | hold_full_reg;

endmodule

// File: tb/tb_piso_tx.sv
// ---------------------------------------------------------------------------
// tb_piso_tx -- scoreboard bench for piso_tx.
// Three instances: 8-bit MSB-first (0), 8-bit LSB-first (1), 2-bit MSB-first
// (2). When a word is accepted, its expected bit stream {bit, first, last} is
// pushed to that instance's queue. A negedge monitor pops one entry per valid
// bit. It also predicts bit_valid, busy and load_ready from the queue depth.
// ---------------------------------------------------------------------------
module tb_piso_tx;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [7:0] par0, par1;
    logic [1:0] par2;
    logic       lv0, lv1, lv2;
    logic       rdy0, so0, bv0, fb0, lb0, bsy0;
    logic       rdy1, so1, bv1, fb1, lb1, bsy1;
    logic       rdy2, so2, bv2, fb2, lb2, bsy2;

    piso_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) u_dut (
        .clk(clk), .rst(rst), .par_in(par0), .load_valid(lv0),
        .load_ready(rdy0), .serial_out(so0), .bit_valid(bv0),
        .first_bit(fb0), .last_bit(lb0), .busy(bsy0));

    piso_tx #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .par_in(par1), .load_valid(lv1),
        .load_ready(rdy1), .serial_out(so1), .bit_valid(bv1),
        .first_bit(fb1), .last_bit(lb1), .busy(bsy1));

    piso_tx #(.WIDTH(2), .MSB_FIRST(1'b1)) u_w2 (
        .clk(clk), .rst(rst), .par_in(par2), .load_valid(lv2),
        .load_ready(rdy2), .serial_out(so2), .bit_valid(bv2),
        .first_bit(fb2), .last_bit(lb2), .busy(bsy2));

    int check_cnt = 0;
    int error_cnt = 0;

    logic [2:0] q0[$];
    logic [2:0] q1[$];
    logic [2:0] q2[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_cnt++;
        if (got !== exp) begin
            error_cnt++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic get_ready(input int which);
        case (which)
            0:       return rdy0;
            1:       return rdy1;
            default: return rdy2;
        endcase
    endfunction

    task automatic drive(input int which, input logic [31:0] word, input logic v);
        case (which)
            0:       begin par0 = word[7:0]; lv0 = v; end
            1:       begin par1 = word[7:0]; lv1 = v; end
            default: begin par2 = word[1:0]; lv2 = v; end
        endcase
    endtask

    task automatic push_word(input int which, input logic [31:0] word);
        int  w;
        logic msb;
        logic b;
        w   = (which == 2) ? 2 : 8;
        msb = (which != 1);
        for (int i = 0; i < w; i++) begin
            b = msb ? word[w-1-i] : word[i];
            case (which)
                0:       q0.push_back({b, i == 0, i == w - 1});
                1:       q1.push_back({b, i == 0, i == w - 1});
                default: q2.push_back({b, i == 0, i == w - 1});
            endcase
        end
    endtask

    // Call just after a negedge; returns just after the negedge that follows
    // the accepting edge, with load_valid still asserted.
    task automatic send(input int which, input logic [31:0] word);
        int t;
        t = 0;
        drive(which, word, 1'b1);
        while (!get_ready(which) && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) begin
            chk("ready_timeout", 32'd1, 32'd0);
        end else begin
            @(posedge clk);
            #1;
            push_word(which, word);
            $display("TX inst=%0d word=%0h accepted at %0t", which, word, $time);
        end
        @(negedge clk);
    endtask

    task automatic mon(input int which, input int w, input logic so, input logic bv,
                       input logic fb, input logic lb, input logic bsy, input logic rdy);
        int sz;
        logic [2:0] e;
        case (which)
            0:       sz = q0.size();
            1:       sz = q1.size();
            default: sz = q2.size();
        endcase
        chk($sformatf("bit_valid[%0d]", which), {31'd0, bv}, {31'd0, sz != 0});
        chk($sformatf("busy[%0d]", which), {31'd0, bsy}, {31'd0, sz != 0});
        chk($sformatf("load_ready[%0d]", which), {31'd0, rdy}, {31'd0, sz <= w});
        if (sz == 0) begin
            chk($sformatf("idle_serial[%0d]", which), {31'd0, so}, 32'd0);
        end else if (bv) begin
            case (which)
                0:       e = q0.pop_front();
                1:       e = q1.pop_front();
                default: e = q2.pop_front();
            endcase
            chk($sformatf("serial_out[%0d]", which), {31'd0, so}, {31'd0, e[2]});
            chk($sformatf("first_bit[%0d]", which), {31'd0, fb}, {31'd0, e[1]});
            chk($sformatf("last_bit[%0d]", which), {31'd0, lb}, {31'd0, e[0]});
        end
    endtask

    always @(negedge clk) if (rst) mon(0, 8, so0, bv0, fb0, lb0, bsy0, rdy0);
    always @(negedge clk) if (rst) mon(1, 8, so1, bv1, fb1, lb1, bsy1, rdy1);
    always @(negedge clk) if (rst) mon(2, 2, so2, bv2, fb2, lb2, bsy2, rdy2);

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_serial"}, {31'd0, so0}, 32'd0);
        chk({tag, "_bit_valid"}, {31'd0, bv0}, 32'd0);
        chk({tag, "_first"}, {31'd0, fb0}, 32'd0);
        chk({tag, "_last"}, {31'd0, lb0}, 32'd0);
        chk({tag, "_busy"}, {31'd0, bsy0}, 32'd0);
        chk({tag, "_ready"}, {31'd0, rdy0}, 32'd1);
        chk({tag, "_ready_w2"}, {31'd0, rdy2}, 32'd1);
    endtask

    initial begin
        rst = 1'b0;
        drive(0, 0, 1'b0);
        drive(1, 0, 1'b0);
        drive(2, 0, 1'b0);
        #1;
        check_reset_outputs("reset");
        repeat (3) @(negedge clk);
        #1 rst = 1'b1;
        @(negedge clk);

        // Single word.
        send(0, 32'hA5);
        drive(0, 0, 1'b0);
        repeat (12) @(negedge clk);

        // Back-to-back.
        send(0, 32'hA5);
        send(0, 32'h3C);
        drive(0, 0, 1'b0);
        repeat (20) @(negedge clk);

        // Backpressure, three words offered continuously.
        send(0, 32'h11);
        send(0, 32'h22);
        send(0, 32'h33);
        drive(0, 0, 1'b0);
        repeat (30) @(negedge clk);

        // Word offered only during the last-bit cycle of the previous one.
        send(0, 32'h81);
        drive(0, 0, 1'b0);
        repeat (7) @(negedge clk);
        send(0, 32'h6E);
        drive(0, 0, 1'b0);
        repeat (12) @(negedge clk);

        // LSB-first.
        send(1, 32'h01);
        send(1, 32'hC4);
        drive(1, 0, 1'b0);
        repeat (20) @(negedge clk);

        // WIDTH=2, second word taken on the last-bit edge.
        send(2, 32'h1);
        drive(2, 0, 1'b0);
        @(negedge clk);
        send(2, 32'h2);
        drive(2, 0, 1'b0);
        repeat (6) @(negedge clk);

        // Reset in the middle of a word with another one held.
        send(0, 32'hFF);
        send(0, 32'h5A);
        drive(0, 0, 1'b0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        q0.delete();
        q1.delete();
        q2.delete();
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
        repeat (6) @(negedge clk);
        chk("post_reset_idle", {31'd0, bv0}, 32'd0);
        send(0, 32'h3C);
        drive(0, 0, 1'b0);
        repeat (12) @(negedge clk);

        chk("queue_drained", q0.size() + q1.size() + q2.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", check_cnt, error_cnt);
        $finish;
    end

endmodule

// File: doc/piso_tx.md
PISO_TX -- requirements
Module: piso_tx

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, word length in bits; legal range 2..32.
REQ-002 The block SHALL have parameter MSB_FIRST, default 1; 1 = MSB shifted out first, 0 = LSB first.
REQ-003 The block SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-004 The block SHALL have port rst  input  1  asynchronous, active-low reset; 0 resets the block.
REQ-005 The block SHALL have port par_in  input  WIDTH  parallel word to transmit.
REQ-006 The block SHALL have port load_valid  input  1  par_in holds a word offered for transmission.
REQ-007 The block SHALL have port load_ready  output  1  block can accept a word this cycle.
REQ-008 The block SHALL have port serial_out  output  1  current transmitted bit.
REQ-009 The block SHALL have port bit_valid  output  1  serial_out carries a valid data bit.
REQ-010 The block SHALL have port first_bit  output  1  serial_out is bit 0 of a word's transmission order.
REQ-011 The block SHALL have port last_bit  output  1  serial_out is the final bit of a word.
REQ-012 The block SHALL have port busy  output  1  shifter or holding register occupied.

Function
REQ-013 Storage SHALL be one WIDTH-bit shift register, one WIDTH-bit holding register with full flag, and a bit counter of $clog2(WIDTH) bits.
REQ-014 The FSM SHALL have states IDLE (shifter empty) and SHIFT (shifter transmitting).
REQ-015 A word SHALL be accepted on a rising edge where load_valid=1 and load_ready=1.
REQ-016 load_ready SHALL equal NOT hold_full, decoded from registers only, with no combinational path from load_valid.
REQ-017 An acceptance in IDLE SHALL load the word directly into the shifter, go to SHIFT, and clear the counter; the first bit appears on serial_out in the cycle after the accepting edge (latency 1).
REQ-018 An acceptance in SHIFT SHALL write the word into the holding register and set hold_full.
REQ-019 In SHIFT, each edge SHALL advance serial_out by one bit and increment the counter; serial_out is driven from the shifter end selected by MSB_FIRST.
REQ-020 bit_valid SHALL be 1 throughout SHIFT and 0 in IDLE.
REQ-021 first_bit SHALL be 1 when counter=0 in SHIFT; last_bit SHALL be 1 when counter=WIDTH-1 in SHIFT.
REQ-022 On the edge ending last_bit with hold_full=1, the holding word SHALL move to the shifter, hold_full clears, the counter resets, and SHIFT is kept with no idle gap.
REQ-023 On the edge ending last_bit with hold_full=0 and no acceptance, the FSM SHALL go to IDLE.
REQ-024 On the edge ending last_bit with hold_full=0 and an acceptance, the new word SHALL go straight into the shifter and SHIFT continues gap-free.
REQ-025 While hold_full=1, no word SHALL be accepted, even on the edge that empties the holding register; load_ready rises the cycle after.
REQ-026 In IDLE, serial_out SHALL be 0.
REQ-027 busy SHALL equal (state==SHIFT) OR hold_full.

Reset
REQ-028 rst=0 SHALL immediately, independent of clk, force state IDLE, counter 0, hold_full 0, and shifter/holding contents 0.
REQ-029 During reset, outputs SHALL be serial_out=0, bit_valid=0, first_bit=0, last_bit=0, busy=0, load_ready=1.
REQ-030 Reset asserted mid-word SHALL discard the word in flight and the held word, with no partial resumption after release.
REQ-031 The first acceptance SHALL occur on the first rising edge after rst returns to 1.

Verification (WIDTH=8 unless stated)
REQ-032 Single word: accept 8'hA5, MSB_FIRST=1 -> serial_out 1,0,1,0,0,1,0,1 on 8 consecutive cycles, first_bit on cycle 1, last_bit on cycle 8, then IDLE with bit_valid=0.
REQ-033 Back-to-back: 8'hA5 then 8'h3C offered continuously -> 16 contiguous bit_valid cycles 10100101 00111100, first_bit at cycles 1 and 9.
REQ-034 Backpressure: three words held valid from cycle 0 -> load_ready=0 after the second acceptance, third word accepted the cycle after hold transfer, 24 contiguous bits, no word lost or duplicated.
REQ-035 LSB-first: MSB_FIRST=0, word 8'h01 -> serial_out 1,0,0,0,0,0,0,0.
REQ-036 Reset mid-word: rst=0 during bit 4 of 8'hFF with a held word -> all outputs at reset values asynchronously, after release bit_valid stays 0 until a new acceptance.
REQ-037 Boundary: WIDTH=2, word 2'b10 accepted on the last_bit edge of a previous word -> gap-free 1,0 with first_bit and last_bit on consecutive cycles.
